vga_sync_decoder: RTL



---
 rtl/vga_timing_pkg.sv | 30 +++
 rtl/vga_edge_detect.sv | 24 ++
 rtl/vga_sync_decoder.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// 640x480 VGA timing constants and decoder types, shared by the timing generator and the
// sync decoder.
package vga_timing_pkg;

  localparam int unsigned H_DISPLAY   = 640;
  localparam int unsigned H_FRONT     = 16;
  localparam int unsigned H_SYNC      = 96;
  localparam int unsigned H_BACK      = 48;
  localparam int unsigned V_DISPLAY   = 480;
  localparam int unsigned V_FRONT     = 10;
  localparam int unsigned V_SYNC      = 2;
  localparam int unsigned V_BACK      = 33;
  localparam int unsigned LOCK_FRAMES = 2;

  localparam int unsigned H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int unsigned V_SYNC_START = V_DISPLAY + V_FRONT;

  typedef enum logic [1:0] {
    StSearch,
    StAcquire,
    StLocked
  } sync_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/vga_edge_detect.sv
// Registers one active-low sync input and flags its falling edge. Both sample registers
// reset high so a line that is already low at reset release reads as a fresh edge.
module vga_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sync,
  output logic fall
);

  logic sample_q, prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q <= 1'b1;
      prev_q   <= 1'b1;
    end else begin
      sample_q <= sync;
      prev_q   <= sample_q;
    end
  end

  assign fall = prev_q & ~sample_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Rebuilds pixel coordinates, display enable and timing lock from an incoming VGA sync pair.
// Define VGA_SYNC_MEASURE_EN to add the measured line/frame length outputs.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY   = vga_timing_pkg::H_DISPLAY,
  parameter int unsigned H_FRONT     = vga_timing_pkg::H_FRONT,
  parameter int unsigned H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int unsigned H_BACK      = vga_timing_pkg::H_BACK,
  parameter int unsigned V_DISPLAY   = vga_timing_pkg::V_DISPLAY,
  parameter int unsigned V_FRONT     = vga_timing_pkg::V_FRONT,
  parameter int unsigned V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int unsigned V_BACK      = vga_timing_pkg::V_BACK,
  parameter int unsigned LOCK_FRAMES = vga_timing_pkg::LOCK_FRAMES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        h_sync,
  input  logic        v_sync,
  output logic [15:0] h_pos,
  output logic [15:0] v_pos,
  output logic        display_on,
  output logic        locked,
  output logic        sync_err
`ifdef VGA_SYNC_MEASURE_EN
  ,
  output logic [15:0] h_total_meas,
  output logic [15:0] v_total_meas
`endif
);

  localparam int unsigned HTot = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTot = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [15:0] HDisp     = 16'(H_DISPLAY);
  localparam logic [15:0] VDisp     = 16'(V_DISPLAY);
  localparam logic [15:0] HLast     = 16'(HTot - 1);
  localparam logic [15:0] VLast     = 16'(VTot - 1);
  localparam logic [15:0] HSyncAt   = 16'(H_DISPLAY + H_FRONT);
  localparam logic [15:0] VSyncAt   = 16'(V_DISPLAY + V_FRONT);
  localparam logic [15:0] HSyncPrev = 16'(H_DISPLAY + H_FRONT - 1);
  localparam logic [15:0] VSyncPrev = 16'(V_DISPLAY + V_FRONT - 1);
  localparam logic [15:0] WdLimit   = 16'(2 * HTot - 1);
  localparam logic [3:0]  LockCnt   = 4'(LOCK_FRAMES);

  logic        h_fall, v_fall;
  logic [15:0] h_pos_d, v_pos_d, wd_q, wd_d;
  logic        h_wrap, line_err, frame_err, err, enter_search;
  logic        h_armed_q, h_armed_d, v_armed_q, v_armed_d;
  logic [3:0]  good_q, good_d, good_inc;
  logic        locked_d, sync_err_d, display_d;
  sync_state_e state_q, state_d;

  vga_edge_detect u_h_edge (
    .clk  (clk),
    .rst  (rst),
    .sync (h_sync),
    .fall (h_fall)
  );

  vga_edge_detect u_v_edge (
    .clk  (clk),
    .rst  (rst),
    .sync (v_sync),
    .fall (v_fall)
  );

  always_comb begin
    h_wrap  = 1'b0;
    h_pos_d = h_pos + 16'd1;
    if (h_fall) begin
      h_pos_d = HSyncAt;
    end else if (h_pos == HLast) begin
      h_pos_d = '0;
      h_wrap  = 1'b1;
    end
  end

  // The v edge load wins over the line increment that normally lands in the same cycle.
  always_comb begin
    v_pos_d = v_pos;
    if (v_fall) begin
      v_pos_d = VSyncAt;
    end else if (h_wrap) begin
      v_pos_d = (v_pos == VLast) ? '0 : v_pos + 16'd1;
    end
  end

  assign wd_d      = h_fall ? '0 : sat_inc16(wd_q);
  assign line_err  = (h_fall && h_armed_q && (h_pos != HSyncPrev)) ||
                     (!h_fall && (wd_q == WdLimit));
  assign frame_err = v_fall && v_armed_q && (v_pos != VSyncPrev);
  assign err       = line_err | frame_err;
  assign good_inc  = good_q + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StSearch;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StSearch:  if (v_fall) state_d = StAcquire;
      StAcquire: begin
        if (err)                                 state_d = StSearch;
        else if (v_fall && (good_inc == LockCnt)) state_d = StLocked;
      end
      StLocked:  if (err) state_d = StSearch;
      default:   state_d = StSearch;
    endcase
  end

  always_comb begin
    good_d = good_q;
    unique case (state_q)
      StSearch:  if (v_fall) good_d = '0;
      StAcquire: if (v_fall && !err) good_d = good_inc;
      default:   ;
    endcase
    sync_err_d   = err && (state_q != StSearch);
    locked_d     = (state_d == StLocked);
    display_d    = locked_d && (h_pos_d < HDisp) && (v_pos_d < VDisp);
    // Edge checks restart from scratch each time lock is abandoned.
    enter_search = (state_d == StSearch) && (state_q != StSearch);
    h_armed_d    = enter_search ? 1'b0 : (h_armed_q | h_fall);
    v_armed_d    = enter_search ? 1'b0 : (v_armed_q | v_fall);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_pos      <= '0;
      v_pos      <= '0;
      wd_q       <= '0;
      good_q     <= '0;
      h_armed_q  <= 1'b0;
      v_armed_q  <= 1'b0;
      locked     <= 1'b0;
      sync_err   <= 1'b0;
      display_on <= 1'b0;
    end else begin
      h_pos      <= h_pos_d;
      v_pos      <= v_pos_d;
      wd_q       <= wd_d;
      good_q     <= good_d;
      h_armed_q  <= h_armed_d;
      v_armed_q  <= v_armed_d;
      locked     <= locked_d;
      sync_err   <= sync_err_d;
      display_on <= display_d;
    end
  end

`ifdef VGA_SYNC_MEASURE_EN
  logic [15:0] lines_q;  // h edges seen since the last v edge

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_total_meas <= '0;
      v_total_meas <= '0;
      lines_q      <= '0;
    end else begin
      if (h_fall) h_total_meas <= sat_inc16(wd_q);
      if (v_fall) begin
        v_total_meas <= h_fall ? sat_inc16(lines_q) : lines_q;
        lines_q      <= '0;
      end else if (h_fall) begin
        lines_q <= sat_inc16(lines_q);
      end
    end
  end
`endif

endmodule
